// File: rtl/fir_filter_param_if.sv
// Host-side handshake bundle for fir_filter_param: request/data inputs from the
// sample source and result/status outputs towards the magnitude consumer.
interface fir_filter_param_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned COEFF_W = 16
) ();
    logic signed [DATA_W-1:0]  sample_data;
    logic signed [COEFF_W-1:0] fir_coefficient;
    logic                      load_coeff;
    logic                      data_ready;
    logic                      modwait;
    logic [DATA_W-1:0]         fir_out;
    logic                      fir_neg;
    logic                      coeff_loaded;
    logic                      one_k_samples;
    logic                      err;

    // Host / sample source side
    modport master (
        output sample_data, fir_coefficient, load_coeff, data_ready,
        input  modwait, fir_out, fir_neg, coeff_loaded, one_k_samples, err
    );

    // Filter side
    modport slave (
        input  sample_data, fir_coefficient, load_coeff, data_ready,
        output modwait, fir_out, fir_neg, coeff_loaded, one_k_samples, err
    );
endinterface

// File: rtl/fir_filter_param.sv
// Sequential-MAC FIR filter: one multiplier-accumulator walks the taps for each
// accepted sample, then reports a saturated sign/magnitude result.
module fir_filter_param #(
    parameter int unsigned DATA_W           = 16,
    parameter int unsigned COEFF_W          = 16,
    parameter int unsigned NUM_TAPS         = 4,
    parameter int unsigned FRAC_BITS        = 15,
    parameter int unsigned SAMPLES_PER_FLAG = 1000
) (
    input logic              clk,
    input logic              reset,
    fir_filter_param_if.slave bus
);
    localparam int unsigned TAP_W  = $clog2(NUM_TAPS);
    localparam int unsigned PROD_W = DATA_W + COEFF_W;
    localparam int unsigned ACC_W  = PROD_W + TAP_W;
    localparam int unsigned CNT_W  = $clog2(SAMPLES_PER_FLAG + 1);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(SAMPLES_PER_FLAG);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StMac, StDone} state_e;

    state_e                    state_q, state_d;
    logic signed [COEFF_W-1:0] coeff_q [NUM_TAPS];
    logic signed [COEFF_W-1:0] coeff_d [NUM_TAPS];
    logic signed [DATA_W-1:0]  x_q [NUM_TAPS];
    logic signed [DATA_W-1:0]  x_d [NUM_TAPS];
    logic signed [DATA_W-1:0]  sample_in_q, sample_in_d;
    logic signed [COEFF_W-1:0] coef_in_q, coef_in_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]          ptr_q, ptr_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]         fir_out_q, fir_out_d;
    logic                      fir_neg_q, fir_neg_d;
    logic                      coeff_loaded_q, coeff_loaded_d;
    logic                      one_k_q, one_k_d;
    logic                      err_q, err_d;

    logic signed [PROD_W-1:0]  x_ext, c_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   res;
    logic [ACC_W-1:0]          mag;
    logic                      sat;
    logic                      busy_req;

    // Datapath: current-tap product and scaled, saturated result of the accumulator
    always_comb begin
        x_ext    = {{COEFF_W{x_q[tap_q][DATA_W-1]}}, x_q[tap_q]};
        c_ext    = {{DATA_W{coeff_q[tap_q][COEFF_W-1]}}, coeff_q[tap_q]};
        prod     = x_ext * c_ext;
        prod_ext = {{TAP_W{prod[PROD_W-1]}}, prod};
        res      = acc_q >>> FRAC_BITS;
        // Unsigned view of -res is correct even for the most negative value
        mag      = res[ACC_W-1] ? -res : res;
        sat      = |mag[ACC_W-1:DATA_W];
        busy_req = (state_q != StIdle) && (bus.data_ready || bus.load_coeff);
    end

    // Next-state logic for the FSM, storage and outputs
    always_comb begin
        state_d        = state_q;
        coeff_d        = coeff_q;
        x_d            = x_q;
        sample_in_d    = sample_in_q;
        coef_in_d      = coef_in_q;
        acc_d          = acc_q;
        ptr_d          = ptr_q;
        tap_d          = tap_q;
        cnt_d          = cnt_q;
        fir_out_d      = fir_out_q;
        fir_neg_d      = fir_neg_q;
        coeff_loaded_d = coeff_loaded_q;
        one_k_d        = 1'b0;
        err_d          = err_q;

        case (state_q)
            StIdle: begin
                if (bus.load_coeff) begin
                    coef_in_d = bus.fir_coefficient;
                    state_d   = StLoad;
                    // Simultaneous sample request loses and is dropped
                    if (bus.data_ready) begin
                        err_d = 1'b1;
                    end
                end else if (bus.data_ready) begin
                    sample_in_d = bus.sample_data;
                    state_d     = StShift;
                end
            end
            StLoad: begin
                coeff_d[ptr_q] = coef_in_q;
                if (ptr_q == LAST_TAP) begin
                    ptr_d          = '0;
                    coeff_loaded_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + TAP_W'(1);
                end
                state_d = StIdle;
            end
            StShift: begin
                for (int k = NUM_TAPS - 1; k > 0; k--) begin
                    x_d[k] = x_q[k-1];
                end
                x_d[0]  = sample_in_q;
                acc_d   = '0;
                tap_d   = '0;
                err_d   = 1'b0;
                state_d = StMac;
            end
            StMac: begin
                acc_d = acc_q + prod_ext;
                if (tap_q == LAST_TAP) begin
                    state_d = StDone;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            StDone: begin
                fir_neg_d = res[ACC_W-1];
                fir_out_d = sat ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
                if (sat) begin
                    err_d = 1'b1;
                end
                if (cnt_q + CNT_W'(1) == CNT_WRAP) begin
                    cnt_d   = '0;
                    one_k_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Requests while busy are ignored but flagged; a set beats the SHIFT clear
        if (busy_req) begin
            err_d = 1'b1;
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff_q[k] <= '0;
                x_q[k]     <= '0;
            end
            sample_in_q    <= '0;
            coef_in_q      <= '0;
            acc_q          <= '0;
            ptr_q          <= '0;
            tap_q          <= '0;
            cnt_q          <= '0;
            fir_out_q      <= '0;
            fir_neg_q      <= 1'b0;
            coeff_loaded_q <= 1'b0;
            one_k_q        <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            coeff_q        <= coeff_d;
            x_q            <= x_d;
            sample_in_q    <= sample_in_d;
            coef_in_q      <= coef_in_d;
            acc_q          <= acc_d;
            ptr_q          <= ptr_d;
            tap_q          <= tap_d;
            cnt_q          <= cnt_d;
            fir_out_q      <= fir_out_d;
            fir_neg_q      <= fir_neg_d;
            coeff_loaded_q <= coeff_loaded_d;
            one_k_q        <= one_k_d;
            err_q          <= err_d;
        end
    end

    assign bus.modwait       = (state_q != StIdle);
    assign bus.fir_out       = fir_out_q;
    assign bus.fir_neg       = fir_neg_q;
    assign bus.coeff_loaded  = coeff_loaded_q;
    assign bus.one_k_samples = one_k_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param against a plain-arithmetic filter model.
module tb_fir_filter_param;
    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int NT  = 4;
    localparam int FB  = 15;
    localparam int SPF = 1000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    fir_filter_param_if #(.DATA_W(DW), .COEFF_W(CW)) bus ();

    fir_filter_param #(
        .DATA_W(DW), .COEFF_W(CW), .NUM_TAPS(NT), .FRAC_BITS(FB), .SAMPLES_PER_FLAG(SPF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: coefficient table, delay line, status as the filter's rules describe
    longint      mc [NT];
    longint      mx [NT];
    int          mptr;
    bit          mloaded;
    bit          merr;
    int          mcount;
    logic [DW-1:0] mout;
    bit          mneg;
    bit          monek;

    function automatic void m_reset();
        for (int k = 0; k < NT; k++) begin
            mc[k] = 0;
            mx[k] = 0;
        end
        mptr = 0; mloaded = 0; merr = 0; mcount = 0; mout = '0; mneg = 0; monek = 0;
    endfunction

    function automatic void m_load(input logic signed [CW-1:0] c);
        mc[mptr] = c;
        mptr = (mptr + 1) % NT;
        if (mptr == 0) mloaded = 1;
    endfunction

    function automatic void m_sample(input logic signed [DW-1:0] s);
        longint sum;
        longint r;
        longint m;
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = s;
        sum = 0;
        for (int k = 0; k < NT; k++) sum += mx[k] * mc[k];
        r    = sum >>> FB;
        mneg = (r < 0);
        m    = mneg ? -r : r;
        merr = (m > 65535);
        mout = merr ? 16'hFFFF : 16'(m);
        mcount++;
        monek = (mcount % SPF == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.modwait === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: modwait still %b after %0d cycles, required 0", bus.modwait, n);
        end
    endtask

    // Counts cycles with modwait high; flags any one_k pulse while busy
    task automatic wait_done(output int cyc, output bit stray);
        cyc = 0;
        stray = 0;
        while (bus.modwait === 1'b1 && cyc < 100) begin
            if (bus.one_k_samples === 1'b1) stray = 1;
            cyc++;
            tick();
        end
    endtask

    task automatic do_load(input logic signed [CW-1:0] c, output int cyc);
        bit stray;
        wait_idle();
        bus.load_coeff = 1'b1;
        bus.fir_coefficient = c;
        tick();
        bus.load_coeff = 1'b0;
        wait_done(cyc, stray);
        m_load(c);
    endtask

    task automatic start_sample(input logic signed [DW-1:0] s);
        wait_idle();
        bus.data_ready = 1'b1;
        bus.sample_data = s;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic do_sample(input logic signed [DW-1:0] s, output int cyc, output bit stray);
        start_sample(s);
        wait_done(cyc, stray);
        m_sample(s);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic check_result(input string name);
        n_checks++;
        if (bus.fir_out !== mout) begin
            n_fail++;
            $display("FAIL %s fir_out: got %0d required %0d", name, bus.fir_out, mout);
        end
        n_checks++;
        if (bus.fir_neg !== mneg) begin
            n_fail++;
            $display("FAIL %s fir_neg: got %b required %b", name, bus.fir_neg, mneg);
        end
        n_checks++;
        if (bus.err !== merr) begin
            n_fail++;
            $display("FAIL %s err: got %b required %b", name, bus.err, merr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.modwait, bus.fir_out, bus.fir_neg, bus.coeff_loaded, bus.one_k_samples,
             bus.err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got modwait=%b fir_out=%0d neg=%b loaded=%b onek=%b err=%b required all 0",
                     bus.modwait, bus.fir_out, bus.fir_neg, bus.coeff_loaded,
                     bus.one_k_samples, bus.err);
        end
    endtask

    task automatic test_basic();
        int cyc;
        bit stray;
        int exp_tab [4] = '{50, 150, 300, 500};
        for (int i = 0; i < NT; i++) begin
            do_load(16'sh4000, cyc);
            n_checks++;
            if (cyc !== 1) begin
                n_fail++;
                $display("FAIL basic_load_wait[%0d]: got %0d cycles required 1", i, cyc);
            end
            n_checks++;
            if (bus.coeff_loaded !== mloaded) begin
                n_fail++;
                $display("FAIL basic_coeff_loaded[%0d]: got %b required %b", i, bus.coeff_loaded, mloaded);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_sample(16'(100 * (i + 1)), cyc, stray);
            n_checks++;
            if (cyc !== NT + 2) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles required %0d", i, cyc, NT + 2);
            end
            n_checks++;
            if (bus.fir_out !== 16'(exp_tab[i])) begin
                n_fail++;
                $display("FAIL basic_value[%0d]: got %0d required %0d", i, bus.fir_out, exp_tab[i]);
            end
            check_result("basic");
        end
    endtask

    task automatic test_negative();
        int cyc;
        bit stray;
        do_load(16'sh8000, cyc);
        for (int i = 1; i < NT; i++) do_load(16'sh0000, cyc);
        do_sample(16'sd1000, cyc, stray);
        n_checks++;
        if (bus.fir_out !== 16'd1000 || bus.fir_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL negative: got fir_out=%0d neg=%b required 1000 neg=1", bus.fir_out, bus.fir_neg);
        end
        check_result("negative");
    endtask

    task automatic test_saturation();
        int cyc;
        bit stray;
        for (int i = 0; i < NT; i++) do_load(16'sh7FFF, cyc);
        for (int i = 0; i < 4; i++) begin
            do_sample(16'sh7FFF, cyc, stray);
            check_result("saturation");
        end
        n_checks++;
        if (bus.fir_out !== 16'hFFFF || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation_clip: got fir_out=%h err=%b required ffff err=1", bus.fir_out, bus.err);
        end
        for (int i = 0; i < NT; i++) do_load(16'sh0000, cyc);
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation_sticky: got err=%b required 1", bus.err);
        end
        do_sample(16'sd5, cyc, stray);
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_clear: got err=%b required 0", bus.err);
        end
        check_result("saturation_after");
    endtask

    task automatic test_busy();
        int cyc;
        bit stray;
        for (int i = 0; i < NT; i++) do_load(16'sh2000, cyc);
        // data_ready during MAC must be ignored
        start_sample(16'sd1234);
        tick();
        tick();
        bus.data_ready = 1'b1;
        bus.sample_data = 16'sd999;
        tick();
        bus.data_ready = 1'b0;
        n_checks++;
        if (bus.modwait !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_modwait: got %b required 1", bus.modwait);
        end
        wait_done(cyc, stray);
        m_sample(16'sd1234);
        merr = 1;
        check_result("busy_data");
        // load_coeff during MAC must not touch the coefficient table
        start_sample(-16'sd4321);
        tick();
        tick();
        bus.load_coeff = 1'b1;
        bus.fir_coefficient = 16'sh7FFF;
        tick();
        bus.load_coeff = 1'b0;
        wait_done(cyc, stray);
        m_sample(-16'sd4321);
        merr = 1;
        check_result("busy_load");
        do_sample(16'sd2500, cyc, stray);
        check_result("busy_after");
    endtask

    task automatic test_both_high();
        int cyc;
        bit stray;
        wait_idle();
        bus.load_coeff = 1'b1;
        bus.data_ready = 1'b1;
        bus.fir_coefficient = 16'sh4000;
        bus.sample_data = 16'sd777;
        tick();
        bus.load_coeff = 1'b0;
        bus.data_ready = 1'b0;
        wait_done(cyc, stray);
        m_load(16'sh4000);
        merr = 1;
        n_checks++;
        if (cyc !== 1 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL both_high: got wait=%0d err=%b required wait=1 err=1", cyc, bus.err);
        end
        do_sample(16'sd10, cyc, stray);
        check_result("both_high_next");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit stray;
        start_sample(16'sd500);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        n_checks++;
        if ({bus.modwait, bus.fir_out, bus.fir_neg, bus.coeff_loaded, bus.one_k_samples,
             bus.err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got modwait=%b fir_out=%0d neg=%b loaded=%b onek=%b err=%b required all 0",
                     bus.modwait, bus.fir_out, bus.fir_neg, bus.coeff_loaded,
                     bus.one_k_samples, bus.err);
        end
        do_sample(16'sd321, cyc, stray);
        n_checks++;
        if (bus.fir_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got fir_out=%0d required 0", bus.fir_out);
        end
        check_result("reset_mid_fresh");
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit stray;
        int pulses = 0;
        int first_at = 0;
        int second_at = 0;
        int bad_wait = 0;
        int strays = 0;
        logic signed [DW-1:0] s;
        apply_reset();
        for (int i = 0; i < NT; i++) do_load(16'($urandom()), cyc);
        for (int i = 1; i <= 2 * SPF; i++) begin
            s = 16'($urandom());
            do_sample(s, cyc, stray);
            if (cyc != NT + 2) bad_wait++;
            if (stray) strays++;
            check_result("b2b");
            n_checks++;
            if (bus.one_k_samples !== monek) begin
                n_fail++;
                $display("FAIL b2b_one_k[%0d]: got %b required %b", i, bus.one_k_samples, monek);
            end
            if (bus.one_k_samples === 1'b1) begin
                pulses++;
                if (pulses == 1) first_at = i;
                if (pulses == 2) second_at = i;
            end
        end
        tick();
        n_checks++;
        if (bus.one_k_samples !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse_width: got one_k=%b one cycle later required 0", bus.one_k_samples);
        end
        n_checks++;
        if (pulses != 2 || first_at != SPF || second_at != 2 * SPF || strays != 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d pulses at %0d,%0d (%0d stray) required 2 at %0d,%0d",
                     pulses, first_at, second_at, strays, SPF, 2 * SPF);
        end
        n_checks++;
        if (bad_wait != 0) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d samples with wrong busy time required 0", bad_wait);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.sample_data = '0;
        bus.fir_coefficient = '0;
        bus.load_coeff = 1'b0;
        bus.data_ready = 1'b0;
        m_reset();
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_busy();
        test_both_high();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_filter_param.md
# fir_filter_param

Parametrised, sequential-MAC FIR filter and the next generation of the lab FIR filter. It accepts signed samples and Q-format coefficients over a single-clock handshake and computes one output per accepted sample with a single multiplier-accumulator. It reports the result as magnitude plus sign with saturation, flags errors, and pulses a sample-count strobe. It sits between the sample source/host interface and the output magnitude consumer.

## Interface
- DATA_W, 16: sample width (signed two's complement); also the fir_out width.
- COEFF_W, 16: coefficient width (signed).
- NUM_TAPS, 4: filter length, ≥2.
- FRAC_BITS, 15: coefficient fractional bits; the accumulator is arithmetically shifted right by this amount.
- SAMPLES_PER_FLAG, 1000: number of completed outputs per one_k_samples pulse.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_data  in  DATA_W  signed sample; captured at acceptance.
- fir_coefficient  in  COEFF_W  signed coefficient; captured at acceptance.
- load_coeff  in  1  request to write fir_coefficient at coefficient pointer.
- data_ready  in  1  request to filter sample_data.
- modwait  out  1  busy; requests are accepted only while modwait is low.
- fir_out  out  DATA_W  unsigned magnitude of the scaled, saturated result.
- fir_neg  out  1  sign of the last result (1 = negative).
- coeff_loaded  out  1  high once NUM_TAPS coefficients have been written since reset.
- one_k_samples  out  1  one-cycle pulse on every SAMPLES_PER_FLAG-th output.
- err  out  1  sticky error flag.

## Operation
- Storage:
  - coeff[0..NUM_TAPS-1] (COEFF_W each).
  - Delay line x[0..NUM_TAPS-1] (DATA_W each; x[0] is the newest sample).
  - Signed accumulator, ACC_W = DATA_W + COEFF_W + ceil(log2(NUM_TAPS)).
  - Coefficient pointer; tap index; output counter.
- FSM states: IDLE, LOAD, SHIFT, MAC, DONE.
- IDLE:
  - load_coeff=1 → LOAD, latching fir_coefficient.
  - Otherwise data_ready=1 → SHIFT, latching sample_data.
  - If both requests are high in the same cycle, load_coeff wins; the sample is dropped and err is set.
- LOAD:
  - Write coeff[ptr]. ptr increments and wraps from NUM_TAPS-1 to 0.
  - Set coeff_loaded when ptr wraps.
  - → IDLE.
- SHIFT: x shifts (x[k] ← x[k-1], x[0] ← latched sample); acc ← 0; tap ← 0; err cleared; → MAC.
- MAC:
  - acc ← acc + x[tap]·coeff[tap] (full-precision signed product).
  - tap increments; after tap NUM_TAPS-1 → DONE.
- DONE:
  - r = acc >>> FRAC_BITS.
  - fir_neg ← (r<0).
  - fir_out ← min(|r|, 2^DATA_W−1). Saturation sets err.
  - Output counter increments; when it reaches SAMPLES_PER_FLAG it resets to 0 and one_k_samples pulses.
  - → IDLE.
- modwait = 1 in every state except IDLE.
- Busy requests: data_ready or load_coeff high while modwait=1 is ignored (no state change) and sets err.
- err clears only on entry to SHIFT (next accepted sample). A set in the same cycle takes priority.
- Coefficients not yet written are 0, so samples filtered before coeff_loaded use zero taps.

## Timing
- Reset values: modwait=0, fir_out=0, fir_neg=0, coeff_loaded=0, one_k_samples=0, err=0. Also coeffs, delay line, acc, ptr and counters are 0; state is IDLE.
- Reset has priority over every other event. Reset asserted mid-computation aborts it: no fir_out update and no one_k pulse.
- Sample latency: data_ready is sampled at edge E0 and modwait=1 after E0. SHIFT executes at E1, MAC at E2..E(NUM_TAPS+1), DONE at E(NUM_TAPS+2). fir_out, fir_neg and one_k_samples update and modwait=0 after E(NUM_TAPS+2), which is 6 edges for the defaults.
- Coefficient latency: load_coeff is sampled at E0; the write happens at E1, and modwait is high for exactly 1 cycle.
- Next request can be accepted at the first edge where modwait is low, giving a throughput of 1 sample per NUM_TAPS+3 cycles.
- one_k_samples is high for exactly the cycle following the DONE edge.

## Test plan
- Load 0x4000 ×4, then samples 100, 200, 300, 400 → fir_out 50, 150, 300, 500; fir_neg=0; err=0; each modwait high 6 cycles; coeff_loaded=1 after the 4th load.
- coeff = {0x8000, 0, 0, 0}, sample 1000 → fir_out=1000, fir_neg=1.
- coeff = 0x7FFF ×4, samples 0x7FFF ×4 → 4th result r=131064 saturates: fir_out=0xFFFF, err=1. The next accepted sample clears err.
- data_ready pulsed during MAC → ignored, err=1, and the in-flight fir_out equals the undisturbed value. load_coeff and data_ready high together in IDLE → coefficient written, sample dropped, err=1.
- 2000 back-to-back samples → one_k_samples pulses exactly at completed outputs 1000 and 2000, one cycle each.
- Reset asserted at the 2nd MAC cycle → next cycle all outputs are 0, state IDLE; a fresh sample with zero coeffs gives fir_out=0.
